// File: rtl/tmds_pkg.sv
// Shared types, code tables and helpers for the multi-lane TMDS encoder.
//   tmds_mode_t   : per-lane symbol mode (CTRL / VIDEO / GUARD / TERC4)
//   CTRL_CODES    : control-period symbols, indexed by {C1,C0}
//   GUARD_CODES   : guard-band symbols, indexed by payload bit 0
//   TERC4_CODES   : TERC4 data-island symbols, indexed by the 4-bit nibble
//   popcount8     : number of ones in a byte
// All symbols are stored with bit 0 as the first bit on the wire.
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'd0,
        MODE_VIDEO = 2'd1,
        MODE_GUARD = 2'd2,
        MODE_TERC4 = 2'd3
    } tmds_mode_t;

    localparam logic [9:0] CTRL_CODES [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam logic [9:0] GUARD_CODES [2] = '{
        10'b1011001100, 10'b0100110011
    };

    localparam logic [9:0] TERC4_CODES [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_multi_encoder_lane.sv
// tmds_lane_core: datapath for one TMDS lane (two register stages plus the
// lane's running-disparity counter). Handshake and valid bits live in the top.
//   clk, n_rst   : clock, asynchronous active-low reset
//   s_rst_i      : synchronous clear of the disparity counter
//   advance_i    : pipeline moves this cycle
//   accept_i     : input beat accepted this cycle (loads stage 1)
//   vld_p1_i     : stage 1 holds a valid symbol
//   mode_i       : lane mode for the incoming beat
//   data_i       : lane payload for the incoming beat
//   sym_o        : encoded 10-bit symbol (stage 2 register)
//   cnt_o        : signed running disparity after the symbol on sym_o
module tmds_lane_core
    import tmds_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    s_rst_i,
    input  logic                    advance_i,
    input  logic                    accept_i,
    input  logic                    vld_p1_i,
    input  tmds_mode_t              mode_i,
    input  logic [7:0]              data_i,
    output logic [9:0]              sym_o,
    output logic signed [CNT_W-1:0] cnt_o
);

    localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] ZERO = '0;

    // Transition-minimised word: XNOR chain when the byte is ones-heavy
    // (ties broken by bit 0), XOR chain otherwise; bit 8 flags XOR.
    function automatic logic [8:0] encode_qm(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    tmds_mode_t              mode_p1_q;
    logic [8:0]              qm_p1_q;
    logic [3:0]              pay_p1_q;
    logic [9:0]              sym_p2_q, sym_p2_d;
    logic signed [CNT_W-1:0] cnt_p2_q, cnt_p2_d;
    logic [3:0]              n1_p2, n0_p2;
    logic signed [CNT_W-1:0] ones_p2, zeros_p2;
    logic                    load_p2;

    // ---- stage 1: q_m and payload capture ----
    always_ff @(posedge clk) begin
        if (accept_i) begin
            mode_p1_q <= mode_i;
            qm_p1_q   <= encode_qm(data_i);
            pay_p1_q  <= data_i[3:0];
        end
    end

    // ---- stage 2: final symbol and disparity update ----
    assign load_p2 = advance_i & vld_p1_i;

    always_comb begin
        sym_p2_d = sym_p2_q;
        cnt_p2_d = cnt_p2_q;
        n1_p2    = popcount8(qm_p1_q[7:0]);
        n0_p2    = 4'd8 - n1_p2;
        ones_p2  = CNT_W'(n1_p2);
        zeros_p2 = CNT_W'(n0_p2);
        case (mode_p1_q)
            MODE_VIDEO: begin
                if ((cnt_p2_q == ZERO) || (n1_p2 == n0_p2)) begin
                    sym_p2_d = {~qm_p1_q[8], qm_p1_q[8],
                                qm_p1_q[8] ? qm_p1_q[7:0] : ~qm_p1_q[7:0]};
                    cnt_p2_d = qm_p1_q[8] ? (cnt_p2_q + ones_p2 - zeros_p2)
                                          : (cnt_p2_q + zeros_p2 - ones_p2);
                end else if ((!cnt_p2_q[CNT_W-1] && (n1_p2 > n0_p2)) ||
                             ( cnt_p2_q[CNT_W-1] && (n0_p2 > n1_p2))) begin
                    // Inverting pulls the disparity back toward zero.
                    sym_p2_d = {1'b1, qm_p1_q[8], ~qm_p1_q[7:0]};
                    cnt_p2_d = cnt_p2_q + (qm_p1_q[8] ? TWO : ZERO) + zeros_p2 - ones_p2;
                end else begin
                    sym_p2_d = {1'b0, qm_p1_q[8], qm_p1_q[7:0]};
                    cnt_p2_d = cnt_p2_q - (qm_p1_q[8] ? ZERO : TWO) + ones_p2 - zeros_p2;
                end
            end
            MODE_CTRL: begin
                sym_p2_d = CTRL_CODES[pay_p1_q[1:0]];
                cnt_p2_d = ZERO;
            end
            MODE_GUARD: begin
                sym_p2_d = GUARD_CODES[pay_p1_q[0]];
                cnt_p2_d = ZERO;
            end
            MODE_TERC4: begin
                sym_p2_d = TERC4_CODES[pay_p1_q];
                cnt_p2_d = ZERO;
            end
        endcase
    end

    // The symbol register keeps its last value on a synchronous clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sym_p2_q <= '0;
            cnt_p2_q <= '0;
        end else if (s_rst_i) begin
            cnt_p2_q <= '0;
        end else if (load_p2) begin
            sym_p2_q <= sym_p2_d;
            cnt_p2_q <= cnt_p2_d;
        end
    end

    assign sym_o = sym_p2_q;
    assign cnt_o = cnt_p2_q;

endmodule

// File: rtl/tmds_multi_encoder.sv
// tmds_multi_encoder: NUM_CH independent TMDS lanes behind one valid/ready
// handshake, two-stage pipeline with a global stall.
//   clk, n_rst          : clock, asynchronous active-low reset
//   s_rst               : synchronous clear (pipeline emptied, counters zeroed)
//   in_valid / in_ready : input handshake
//   in_mode             : 2 bits per lane (CTRL/VIDEO/GUARD/TERC4)
//   in_data             : 8 bits per lane
//   out_valid/out_ready : output handshake
//   out_sym             : 10 bits per lane, lane k at [10k+9:10k]
//   out_disp            : signed running disparity per lane, CNT_W bits each
module tmds_multi_encoder
    import tmds_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      s_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*NUM_CH-1:0]       in_mode,
    input  logic [8*NUM_CH-1:0]       in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [10*NUM_CH-1:0]      out_sym,
    output logic [CNT_W*NUM_CH-1:0]   out_disp
);

    logic                    advance;
    logic                    accept;
    logic                    vld_p1_q;
    logic                    vld_p2_q;
    logic [9:0]              sym_lane [NUM_CH];
    logic signed [CNT_W-1:0] cnt_lane [NUM_CH];

    // Whole pipeline moves together whenever the output slot is free.
    assign advance   = !vld_p2_q | out_ready;
    assign accept    = in_valid & advance;
    assign in_ready  = advance;
    assign out_valid = vld_p2_q;

    // ---- stage 1 / stage 2 valid bits ----
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else if (s_rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else if (advance) begin
            vld_p1_q <= accept;
            vld_p2_q <= vld_p1_q;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        tmds_lane_core #(
            .CNT_W (CNT_W)
        ) u_lane (
            .clk       (clk),
            .n_rst     (n_rst),
            .s_rst_i   (s_rst),
            .advance_i (advance),
            .accept_i  (accept),
            .vld_p1_i  (vld_p1_q),
            .mode_i    (tmds_mode_t'(in_mode[2*k +: 2])),
            .data_i    (in_data[8*k +: 8]),
            .sym_o     (sym_lane[k]),
            .cnt_o     (cnt_lane[k])
        );
    end

    always_comb begin
        out_sym  = '0;
        out_disp = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            out_sym[10*k +: 10]        = sym_lane[k];
            out_disp[CNT_W*k +: CNT_W] = cnt_lane[k];
        end
    end

endmodule

// File: tb/tb_tmds_multi_encoder.sv
`timescale 1ns/1ps
module tb_tmds_multi_encoder;

    localparam int NCH = 3;
    localparam int CW  = 5;

    logic              clk;
    logic              n_rst;
    logic              s_rst;
    logic              in_valid;
    logic              in_ready;
    logic [2*NCH-1:0]  in_mode;
    logic [8*NCH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [10*NCH-1:0] out_sym;
    logic [CW*NCH-1:0] out_disp;

    tmds_multi_encoder #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .s_rst     (s_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_disp  (out_disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_cnt [NCH];

    localparam logic [9:0] REF_CTRL [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };
    localparam logic [9:0] REF_TERC [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    typedef struct {
        logic [10*NCH-1:0] sym;
        logic [CW*NCH-1:0] disp;
        int                tag;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic [9:0] sym;
        int         disp;
    } vec_t;
    vec_t vt [13];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference encoder for one lane; updates the model disparity counter.
    function automatic void model_lane(input int k, input logic [1:0] mode,
                                       input logic [7:0] d, output logic [9:0] sym);
        logic [8:0] q;
        int ones, n1, n0;
        bit xn;
        sym = '0;
        case (mode)
            2'd0: begin sym = REF_CTRL[d[1:0]]; m_cnt[k] = 0; end
            2'd2: begin sym = d[0] ? 10'b0100110011 : 10'b1011001100; m_cnt[k] = 0; end
            2'd3: begin sym = REF_TERC[d[3:0]]; m_cnt[k] = 0; end
            default: begin
                ones = $countones(d);
                xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
                q    = '0;
                q[0] = d[0];
                for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
                q[8] = !xn;
                n1 = $countones(q[7:0]);
                n0 = 8 - n1;
                if (m_cnt[k] == 0 || n1 == n0) begin
                    if (q[8]) begin sym = {2'b01, q[7:0]};  m_cnt[k] += n1 - n0; end
                    else      begin sym = {2'b10, ~q[7:0]}; m_cnt[k] += n0 - n1; end
                end else if ((m_cnt[k] > 0 && n1 > n0) || (m_cnt[k] < 0 && n0 > n1)) begin
                    sym = {1'b1, q[8], ~q[7:0]};
                    m_cnt[k] += (q[8] ? 2 : 0) + n0 - n1;
                end else begin
                    sym = {1'b0, q[8], q[7:0]};
                    m_cnt[k] += n1 - n0 - (q[8] ? 0 : 2);
                end
            end
        endcase
    endfunction

    // Drive one beat; expected result is queued at the accepting edge.
    task automatic send(input logic [2*NCH-1:0] modes, input logic [8*NCH-1:0] data,
                        input int tag, input bit use_exp, input logic [9:0] xsym, input int xdisp);
        exp_t e;
        logic [9:0] s;
        logic [4:0] xd;
        in_valid = 1'b1;
        in_mode  = modes;
        in_data  = data;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                for (int k = 0; k < NCH; k++) begin
                    model_lane(k, modes[2*k +: 2], data[8*k +: 8], s);
                    e.sym[10*k +: 10] = s;
                    e.disp[CW*k +: CW] = m_cnt[k][CW-1:0];
                end
                if (use_exp) begin
                    xd = xdisp[4:0];
                    e.sym  = {NCH{xsym}};
                    e.disp = {NCH{xd}};
                end
                e.tag = tag;
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk($sformatf("handshake_timeout_%0d", tag), 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic clear_model();
        sb.delete();
        for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
    endtask

    // Output monitor: a beat transfers at the next rising edge.
    always @(negedge clk) begin
        if (n_rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_sym), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("sym_%0d", mon_e.tag), 32'(out_sym), 32'(mon_e.sym));
                chk($sformatf("disp_%0d", mon_e.tag), 32'(out_disp), 32'(mon_e.disp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{2'd1, 8'h00, 10'b0100000000, -8};
        vt[1]  = '{2'd1, 8'h00, 10'b1111111111,  2};
        vt[2]  = '{2'd0, 8'h00, 10'b1101010100,  0};
        vt[3]  = '{2'd0, 8'h01, 10'b0010101011,  0};
        vt[4]  = '{2'd0, 8'h02, 10'b0101010100,  0};
        vt[5]  = '{2'd0, 8'h03, 10'b1010101011,  0};
        vt[6]  = '{2'd1, 8'hFF, 10'b1000000000, -8};
        vt[7]  = '{2'd2, 8'h01, 10'b0100110011,  0};
        vt[8]  = '{2'd1, 8'h00, 10'b0100000000, -8};
        vt[9]  = '{2'd1, 8'h10, 10'b0111110000, -8};
        vt[10] = '{2'd1, 8'hFF, 10'b0011111111, -2};
        vt[11] = '{2'd3, 8'h05, 10'b0100011110,  0};
        vt[12] = '{2'd2, 8'h00, 10'b1011001100,  0};

        n_rst = 1'b1; s_rst = 1'b0; in_valid = 1'b0;
        in_mode = '0; in_data = '0; out_ready = 1'b1;
        for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
        #1 n_rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sym",   32'(out_sym),   32'd0);
        chk("rst_out_disp",  32'(out_disp),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors, identical on every lane.
        for (int i = 0; i < 13; i++) begin
            send({NCH{vt[i].mode}}, {NCH{vt[i].data}}, i, 1'b1, vt[i].sym, vt[i].disp);
        end
        drain("table_drain");

        // Stall of three cycles in the middle of a short stream.
        repeat (2) @(posedge clk); #1;
        fork
            begin
                send({NCH{2'd1}}, 24'h302010, 100, 1'b0, '0, 0);
                send({NCH{2'd1}}, 24'h103020, 101, 1'b0, '0, 0);
                send({NCH{2'd1}}, 24'h201030, 102, 1'b0, '0, 0);
            end
            begin
                for (int t = 0; t < 20 && !out_valid; t++) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("stall_drain");

        // TERC4 sweep on lane 2, random video on lanes 0/1.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] nib;
            nib = 4'(i);
            send({2'd3, 2'd1, 2'd1},
                 {4'h0, nib, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))},
                 200 + i, 1'b0, '0, 0);
        end
        drain("terc4_drain");

        // Random mixed modes with random back-pressure.
        fork
            for (int i = 0; i < 24; i++) begin
                send(6'($urandom_range(0, 63)),
                     {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))},
                     300 + i, 1'b0, '0, 0);
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain("random_drain");

        // Synchronous clear with two symbols in flight during a stall.
        out_ready = 1'b0;
        send({NCH{2'd0}}, {NCH{8'h03}}, 400, 1'b1, 10'b1010101011, 0);
        send({NCH{2'd1}}, {NCH{8'hFF}}, 401, 1'b0, '0, 0);
        s_rst = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        chk("srst_out_valid", 32'(out_valid), 32'd0);
        chk("srst_out_disp",  32'(out_disp),  32'd0);
        chk("srst_sym_hold",  32'(out_sym),   32'({NCH{10'b1010101011}}));
        clear_model();
        @(posedge clk); #1;
        chk("srst_dropped", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send({NCH{2'd1}}, {NCH{8'h00}}, 402, 1'b1, 10'b0100000000, -8);
        drain("srst_drain");

        // Asynchronous reset pulse mid-stream.
        send({NCH{2'd1}}, 24'h55AA0F, 500, 1'b0, '0, 0);
        send({NCH{2'd1}}, 24'h123456, 501, 1'b0, '0, 0);
        #1 n_rst = 1'b0;
        #1;
        chk("nrst_out_valid", 32'(out_valid), 32'd0);
        chk("nrst_out_sym",   32'(out_sym),   32'd0);
        chk("nrst_out_disp",  32'(out_disp),  32'd0);
        clear_model();
        @(negedge clk) n_rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("nrst_quiet", 32'(out_valid), 32'd0);
        end
        send({NCH{2'd1}}, {NCH{8'h00}}, 502, 1'b1, 10'b0100000000, -8);
        drain("nrst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmds_multi_encoder.md
Name: tmds_multi_encoder

Overview:
Parametrised multi-channel TMDS symbol encoder replacing the per-channel fixed pipeline. Each of NUM_CH lanes takes a per-symbol mode (control, video, guard, TERC4) and produces a 10-bit TMDS symbol. Video symbols are DC-balanced with a running-disparity counter per lane. Sits between the timing/TMDS controller and the serializers, with a valid/ready handshake on both sides.

Parameters:
NUM_CH, 3, number of independent lanes (1..4)
CNT_W, 5, signed running-disparity counter width (min 5)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
s_rst  in  1  synchronous clear: empties the pipeline and zeroes all disparity counters
in_valid  in  1  input symbol set valid
in_ready  out  1  encoder can accept this cycle
in_mode  in  2*NUM_CH  per-lane mode: 0 CTRL, 1 VIDEO, 2 GUARD, 3 TERC4
in_data  in  8*NUM_CH  per-lane payload: VIDEO uses [7:0], TERC4 uses [3:0], CTRL uses [1:0], GUARD uses [0]
out_valid  out  1  symbol set valid
out_ready  in  1  downstream accepts
out_sym  out  10*NUM_CH  per-lane encoded symbol; lane k is bits [10k+9:10k]; bit 0 is transmitted first
out_disp  out  CTRL_W*NUM_CH  debug: current signed counter per lane (CTRL_W=CNT_W)

Behaviour:
- Reset (n_rst low, async): out_valid=0, out_sym=0, out_disp=0, all stage valids 0, counters 0. in_ready=1 after reset.
- Pipeline: 2 register stages. Stage 1 latches q_m[8:0] plus mode/payload. Stage 2 latches the final symbol. Latency is 2 accepted cycles from input handshake to out_valid.
- Global stall: advance = !out_valid | out_ready; in_ready = advance. All stages and counters hold when advance=0. Input accepted when in_valid & in_ready. A bubble propagates as stage-valid=0.
- Stage 1 (VIDEO), n1 = popcount(D):
  - If n1>4, or n1==4 with D[0]==0: use the XNOR chain and q_m[8]=0.
  - Otherwise use the XOR chain and q_m[8]=1.
  - In both cases q_m[0]=D[0] and q_m[i]=q_m[i-1] op D[i].
- Stage 2 (VIDEO), with N1/N0 = ones/zeros of q_m[7:0]:
  - If cnt==0 or N1==N0: sym = {~q_m8, q_m8, q_m8 ? q_m : ~q_m}. cnt += q_m8 ? (N1-N0) : (N0-N1).
  - Else if (cnt>0 & N1>N0) or (cnt<0 & N0>N1): sym = {1, q_m8, ~q_m}. cnt += 2*q_m8 + (N0-N1).
  - Else: sym = {0, q_m8, q_m}. cnt += -2*(~q_m8) + (N1-N0).
  - Arithmetic is signed CNT_W. Range is bounded to ±10 and never wraps.
- CTRL codes: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- GUARD codes: bit0=0→1011001100, bit0=1→0100110011.
- TERC4: 16-entry constant table.
- Any non-VIDEO symbol entering stage 2 zeroes that lane's counter.
- Lanes are fully independent except for the shared handshake. Mixed modes across lanes in one beat are legal.
- The counter updates only when stage 2 loads a valid VIDEO symbol. It is unchanged on bubbles and stalls.
- s_rst has priority over advance: stage valids go to 0, counters go to 0, out_sym holds its value. Asserting s_rst mid-stall drops the pending symbol.
- Reset mid-operation discards all in-flight symbols. There is no partial output.

Decomposition:
- Package tmds_pkg holds:
  - typedef tmds_mode_t (CTRL/VIDEO/GUARD/TERC4)
  - CTRL_CODES[4], GUARD_CODES[2], TERC4_CODES[16] as 10-bit constants
  - function popcount8
- One sub-module, tmds_lane_core, instantiated NUM_CH times via generate. It contains the stage 1/2 logic and its own disparity counter, takes advance/s_rst/accept as inputs, and exposes sym and cnt.
- The top level holds the handshake and valid bits.

Test Plan:
- After reset, VIDEO 0x00 on lane 0 with out_ready=1 → 2 cycles later sym=0100000000, disp=-8. Next 0x00 → sym=1111111111, disp=+2.
- CTRL 00,01,10,11 back-to-back on all lanes → 1101010100, 0010101011, 0101010100, 1010101011 on consecutive cycles. Disparity remains 0.
- VIDEO 0xFF to reach disp≠0, then GUARD bit0=1 → sym=0100110011 and disp=0. Next VIDEO 0x00 encodes as at the cnt==0 start (0100000000).
- Stream 0x10,0x20,0x30 with out_ready low for 3 cycles mid-stream → in_ready=0 during the stall. No symbol is lost or duplicated, and the output order and disparity trajectory match the no-stall reference model.
- TERC4 sweep 0..15 on lane 2 with random VIDEO on lanes 0/1 → lane 2 outputs match TERC4_CODES. Lanes 0/1 match the reference model.
- s_rst asserted with 2 symbols in flight → out_valid=0 next cycle, all disp=0. A subsequent 0x00 gives 0100000000. Async n_rst pulse mid-stream → immediate out_valid=0.
